calc_display_ctrl: RTL and testbench
====================================

Name: calc_display_ctrl

Overview:
Receiver side of the calculator's digit-print stream (status/data/pos). It captures the serialized decimal digits into a shadow buffer and commits a complete 8-digit frame atomically. It then drives 8 multiplexed, active-low seven-segment displays from the committed frame. It sits between the calc core and the board's display pins, and shows "Err" whenever the core reports the error status.

Parameters:
REFRESH_DIV, 50000, clock cycles each digit stays lit during scanning (>=2)
NUM_DIGITS, 8, number of display digits; fixed at 8 in this revision

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high
status  input  2  core status: 00 error, 01 busy, 10 ready, 11 printing
data  input  4  digit value (0-9 valid) accompanying pos
pos  input  4  post-increment digit index from core, 0..8
seg  output  8  segments active-low; seg[6:0]=g..a, seg[7]=dp
an  output  8  digit enables active-low, one-hot; an[0]=rightmost (least significant)
frame_commit  output  1  one-cycle pulse when a complete frame is committed
err_active  output  1  high while the error message is displayed

Behaviour:
- Reset is asynchronous, active-high; the clock is clock. On reset: shadow and committed buffers = all 0, state IDLE, scan index 0, refresh counter 0, seg=8'hFF, an=8'hFF, frame_commit=0, err_active=0.
- Stream protocol: in each cycle with status==11 and pos in 1..8, data belongs to digit pos-1 and is written to shadow[pos-1]. Cycles with pos==0, or with pos already written in the current frame, are ignored (no double write).
- A written-mask (8 bits) tracks captured digits. It clears on entry to CAPTURE.
- FSM states: IDLE, CAPTURE, COMMIT, ERROR.
  - IDLE: status==11 -> CAPTURE. status==00 -> ERROR.
  - CAPTURE: writes shadow. When status leaves 11: if mask==8'hFF -> COMMIT; otherwise the frame is incomplete and is discarded -> IDLE, with the committed buffer unchanged. status==00 -> ERROR (shadow discarded).
  - COMMIT: for one cycle, committed <= shadow and frame_commit=1. Then -> IDLE, or -> CAPTURE if status==11 in that cycle.
  - ERROR: err_active=1 (registered; it asserts the cycle after entry). Exit to IDLE when status==10. Exit to CAPTURE when status==11; err_active drops the same cycle.
- Latency: the committed frame is visible on the scan starting no later than the next digit-period boundary after the frame_commit pulse.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1. On wrap, the scan index increments modulo 8.
  - an and seg are registered and update together; an = ~(1<<scan index).
  - The first clock after reset loads an=8'hFE and seg=code(committed[0]).
- Segment codes (g..a, active-low), dp always 1:
  - digits 0-9 = 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000
  - values 10-15 show dash = 0111111
  - blank = 1111111
  - E = 0000110
  - r = 0101111
- Error display: digit2=E, digit1=r, digit0=r, digits 7..3 blank.
- Simultaneous events: status==00 takes priority over capture and commit in the same cycle. A refresh wrap coinciding with COMMIT shows the new frame on the new digit.
- Reset mid-capture or mid-commit: everything returns to reset values; no partial frame survives.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: starting from digit 7 downward, every committed digit equal to 0 is shown blank until the first nonzero digit. Digit 0 is never blanked, so value 0 shows a single "0".
- Undefined: all 8 digits are always shown, including leading zeros. The error display is unaffected either way.

Test Plan:
- Reset, then idle 8*REFRESH_DIV cycles (REFRESH_DIV=4) -> an cycles FE,FD,...,7F. seg=1000000 on every digit without LEADING_ZERO_BLANK_EN; with it, only digit 0 shows 1000000 and the rest 1111111.
- Stream 123 (status=11, pos 1..8, data 3,2,1,0,0,0,0,0, then status=10) -> one frame_commit pulse. Digit0=0110000, digit1=0100100, digit2=1111001; digits 3-7 blank with LEADING_ZERO_BLANK_EN.
- Partial frame (pos 1..5 then status=10) -> no frame_commit; display still shows the previous "123".
- status=00 during CAPTURE -> err_active=1 next cycle; digits 2..0 = E,r,r, others blank. status=10 -> err_active=0 and the previous committed frame is shown again.
- Repeated pos value (pos=3 held 3 cycles with data 7,9,9) -> digit2 holds 7. Data 12 at pos 4 -> digit3 shows 0111111.
- Assert reset mid-capture at pos=5 -> seg=FF, an=FF immediately. After release, a full zero frame is displayed with no commit pulse.

Source files
------------

// File: rtl/calc_display_ctrl.sv
// Digit-print stream receiver plus 8-digit multiplexed seven-segment driver.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zeros of the committed frame).

module calc_display_glyph #(
  parameter int DIGIT = 0
) (
  input  logic [3:0] value,
  input  logic       blank,
  input  logic       err,
  output logic [7:0] seg
);
  // Glyph codes are {dp, g..a}, all active-low; dp is never lit.
  localparam logic [7:0] G_BLANK = 8'hFF;
  localparam logic [7:0] G_E     = 8'h86;
  localparam logic [7:0] G_R     = 8'hAF;

  always_comb begin
    seg = G_BLANK;
    if (err) begin
      if (DIGIT == 2)     seg = G_E;
      else if (DIGIT < 2) seg = G_R;
    end else if (!blank) begin
      case (value)
        4'd0:    seg = 8'hC0;
        4'd1:    seg = 8'hF9;
        4'd2:    seg = 8'hA4;
        4'd3:    seg = 8'hB0;
        4'd4:    seg = 8'h99;
        4'd5:    seg = 8'h92;
        4'd6:    seg = 8'h82;
        4'd7:    seg = 8'hF8;
        4'd8:    seg = 8'h80;
        4'd9:    seg = 8'h90;
        default: seg = 8'hBF;
      endcase
    end
  end
endmodule

module calc_display_ctrl #(
  parameter int REFRESH_DIV = 50000,
  parameter int NUM_DIGITS  = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] status,
  input  logic [3:0] data,
  input  logic [3:0] pos,
  output logic [7:0] seg,
  output logic [7:0] an,
  output logic       frame_commit,
  output logic       err_active
);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [1:0] ST_ERR = 2'b00;
  localparam logic [1:0] ST_RDY = 2'b10;
  localparam logic [1:0] ST_PRN = 2'b11;

  typedef enum logic [1:0] {IDLE, CAPTURE, COMMIT, ERROR} state_t;

  state_t                       state;
  logic [NUM_DIGITS-1:0][3:0]   shadow, committed;
  logic [NUM_DIGITS-1:0]        mask;
  logic [2:0]                   scan_idx;
  logic [CW-1:0]                refcnt;
  logic [NUM_DIGITS-1:0]        lead_blank;
  logic [NUM_DIGITS-1:0][7:0]   glyph;

  logic                         wr_valid, shadow_we;
  logic [2:0]                   wr_idx;
  logic [NUM_DIGITS-1:0]        wr_bit;

  assign wr_valid = (status == ST_PRN) && (pos != 4'd0) && (pos <= 4'd8);
  assign wr_idx   = 3'(pos - 4'd1);
  assign wr_bit   = wr_valid ? (NUM_DIGITS'(1) << wr_idx) : '0;
  // Every state that sees a valid write either is, or is entering, CAPTURE;
  // only an already-captured position inside CAPTURE is suppressed.
  assign shadow_we = wr_valid && !(state == CAPTURE && mask[wr_idx]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow <= '0;
    end else if (shadow_we) begin
      shadow[wr_idx] <= data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      mask         <= '0;
      committed    <= '0;
      frame_commit <= 1'b0;
      err_active   <= 1'b0;
    end else begin
      frame_commit <= 1'b0;
      case (state)
        IDLE: begin
          if (status == ST_ERR) begin
            state      <= ERROR;
            err_active <= 1'b1;
          end else if (status == ST_PRN) begin
            state <= CAPTURE;
            mask  <= wr_bit;
          end
        end
        CAPTURE: begin
          if (status == ST_ERR) begin
            state      <= ERROR;
            err_active <= 1'b1;
          end else if (status == ST_PRN) begin
            mask <= mask | wr_bit;
          end else if (&mask) begin
            state <= COMMIT;
          end else begin
            state <= IDLE;
          end
        end
        COMMIT: begin
          // An error reported in the commit cycle wins: the frame is dropped.
          if (status == ST_ERR) begin
            state      <= ERROR;
            err_active <= 1'b1;
          end else begin
            committed    <= shadow;
            frame_commit <= 1'b1;
            if (status == ST_PRN) begin
              state <= CAPTURE;
              mask  <= wr_bit;
            end else begin
              state <= IDLE;
            end
          end
        end
        ERROR: begin
          if (status == ST_RDY) begin
            state      <= IDLE;
            err_active <= 1'b0;
          end else if (status == ST_PRN) begin
            state      <= CAPTURE;
            mask       <= wr_bit;
            err_active <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    lead_blank = '0;
    lead_blank[NUM_DIGITS-1] = (committed[NUM_DIGITS-1] == 4'd0);
    for (int i = NUM_DIGITS - 2; i >= 1; i--)
      lead_blank[i] = lead_blank[i+1] && (committed[i] == 4'd0);
  end
`else
  assign lead_blank = '0;
`endif

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_glyph
    calc_display_glyph #(.DIGIT(d)) u_glyph (
      .value (committed[d]),
      .blank (lead_blank[d]),
      .err   (err_active),
      .seg   (glyph[d])
    );
  end

  // an/seg are re-evaluated every cycle, so a new frame or error state shows
  // on whatever digit is currently being scanned without waiting for a wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      refcnt   <= '0;
      scan_idx <= '0;
      an       <= 8'hFF;
      seg      <= 8'hFF;
    end else begin
      if (refcnt == CW'(REFRESH_DIV - 1)) begin
        refcnt   <= '0;
        scan_idx <= scan_idx + 3'd1;
      end else begin
        refcnt <= refcnt + CW'(1);
      end
      an  <= ~(8'd1 << scan_idx);
      seg <= glyph[scan_idx];
    end
  end
endmodule

// File: tb/tb_calc_display_ctrl.sv
// Directed bench for calc_display_ctrl; honours LEADING_ZERO_BLANK_EN when defined.

module tb_calc_display_ctrl;
  localparam int DIV = 4;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [7:0] LZ = 8'hFF;
`else
  localparam logic [7:0] LZ = 8'hC0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] status;
  logic [3:0] data, pos;
  logic [7:0] seg, an;
  logic       frame_commit, err_active;

  int passed = 0;
  int total  = 0;
  int commits = 0;
  int c0;
  logic [7:0] got   [8];
  logic [7:0] exp_d [8];

  calc_display_ctrl #(.REFRESH_DIV(DIV), .NUM_DIGITS(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .status       (status),
    .data         (data),
    .pos          (pos),
    .seg          (seg),
    .an           (an),
    .frame_commit (frame_commit),
    .err_active   (err_active)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (frame_commit === 1'b1) commits++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic step(input logic [1:0] s, input logic [3:0] p, input logic [3:0] d);
    @(negedge clock);
    status = s;
    pos    = p;
    data   = d;
  endtask

  task automatic scan_frame();
    for (int i = 0; i < 8; i++) got[i] = 8'hxx;
    for (int k = 0; k < 9 * DIV; k++) begin
      @(negedge clock);
      for (int i = 0; i < 8; i++)
        if (an === ~(8'd1 << i)) got[i] = seg;
    end
  endtask

  task automatic check_frame(input string tag);
    scan_frame();
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_d%0d", tag, i), {24'd0, got[i]}, {24'd0, exp_d[i]});
  endtask

  initial begin
    reset = 1'b1; status = 2'b10; pos = 4'd0; data = 4'd0;
    repeat (3) @(negedge clock);
    check("rst_seg", {24'd0, seg}, 32'hFF);
    check("rst_an",  {24'd0, an},  32'hFF);
    check("rst_fc",  {31'd0, frame_commit}, 32'd0);
    check("rst_err", {31'd0, err_active},   32'd0);
    reset = 1'b0;

    // idle scan: each digit held DIV cycles, FE first
    for (int k = 0; k < 8 * DIV; k++) begin
      @(negedge clock);
      if (k % DIV == 0) begin
        check($sformatf("idle_an%0d", k / DIV), {24'd0, an}, {24'd0, ~(8'd1 << (k / DIV))});
        check($sformatf("idle_seg%0d", k / DIV), {24'd0, seg}, (k == 0) ? 32'hC0 : {24'd0, LZ});
      end
    end

    // full frame "123"
    c0 = commits;
    for (int p = 1; p <= 8; p++) step(2'b11, 4'(p), (p <= 3) ? 4'(4 - p) : 4'd0);
    step(2'b10, 4'd0, 4'd0);
    repeat (4) @(negedge clock);
    check("commit_123", commits - c0, 1);
    exp_d = '{8'hB0, 8'hA4, 8'hF9, LZ, LZ, LZ, LZ, LZ};
    check_frame("f123");

    // partial frame is discarded
    c0 = commits;
    for (int p = 1; p <= 5; p++) step(2'b11, 4'(p), 4'd9);
    step(2'b10, 4'd0, 4'd0);
    repeat (4) @(negedge clock);
    check("commit_partial", commits - c0, 0);
    check_frame("partial");

    // error during capture
    step(2'b11, 4'd1, 4'd5);
    step(2'b11, 4'd2, 4'd5);
    step(2'b00, 4'd0, 4'd0);
    @(negedge clock);
    check("err_on", {31'd0, err_active}, 32'd1);
    exp_d = '{8'hAF, 8'hAF, 8'h86, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    check_frame("errdisp");
    step(2'b10, 4'd0, 4'd0);
    @(negedge clock);
    check("err_off", {31'd0, err_active}, 32'd0);
    repeat (2) @(negedge clock);
    exp_d = '{8'hB0, 8'hA4, 8'hF9, LZ, LZ, LZ, LZ, LZ};
    check_frame("after_err");

    // repeated pos and out-of-range digit value
    c0 = commits;
    step(2'b11, 4'd1, 4'd1);
    step(2'b11, 4'd2, 4'd2);
    step(2'b11, 4'd3, 4'd7);
    step(2'b11, 4'd3, 4'd9);
    step(2'b11, 4'd3, 4'd9);
    step(2'b11, 4'd4, 4'd12);
    for (int p = 5; p <= 8; p++) step(2'b11, 4'(p), 4'd0);
    step(2'b10, 4'd0, 4'd0);
    repeat (4) @(negedge clock);
    check("commit_rep", commits - c0, 1);
    exp_d = '{8'hF9, 8'hA4, 8'hF8, 8'hBF, LZ, LZ, LZ, LZ};
    check_frame("rep");

    // reset mid-capture
    c0 = commits;
    for (int p = 1; p <= 5; p++) step(2'b11, 4'(p), 4'd4);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("midrst_seg", {24'd0, seg}, 32'hFF);
    check("midrst_an",  {24'd0, an},  32'hFF);
    check("midrst_fc",  {31'd0, frame_commit}, 32'd0);
    @(negedge clock);
    status = 2'b10; pos = 4'd0; data = 4'd0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_an",  {24'd0, an},  32'hFE);
    check("post_rst_seg", {24'd0, seg}, 32'hC0);
    repeat (4) @(negedge clock);
    check("commit_midrst", commits - c0, 0);
    check("post_rst_err", {31'd0, err_active}, 32'd0);
    exp_d = '{8'hC0, LZ, LZ, LZ, LZ, LZ, LZ, LZ};
    check_frame("zero");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
